// File: rtl/mvm_uart_pkg.sv
// Shared constants, size helpers and tx frame state encoding for the MVM UART link.
package mvm_uart_pkg;

  localparam int unsigned CLOCKS_PER_PULSE_DEF = 10;
  localparam int unsigned BITS_PER_WORD_DEF    = 8;
  localparam int unsigned PACKET_SIZE_TX_DEF   = 13;

  // Frame = 1 start + data + stop; callers must guarantee packet_size >= bits_per_word + 2.
  function automatic int unsigned stop_bits(int unsigned packet_size, int unsigned bits_per_word);
    return packet_size - bits_per_word - 1;
  endfunction

  function automatic int unsigned num_words(int unsigned r, int unsigned w_y,
                                            int unsigned bits_per_word);
    return (r * w_y) / bits_per_word;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

endpackage

// File: rtl/uart_tx_frame.sv
// Single-word UART serialiser: start bit, LSB-first data, stop bits. Owns baud and bit counters.
module uart_tx_frame
  import mvm_uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = CLOCKS_PER_PULSE_DEF,
  parameter int unsigned BITS_PER_WORD    = BITS_PER_WORD_DEF,
  parameter int unsigned PACKET_SIZE_TX   = PACKET_SIZE_TX_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [BITS_PER_WORD-1:0] data,
  output logic                     done,
  output logic                     tx
);

  localparam int unsigned STOP_BITS = stop_bits(PACKET_SIZE_TX, BITS_PER_WORD);
  localparam int unsigned BAUD_W    = $clog2(CLOCKS_PER_PULSE);
  localparam int unsigned BIT_W     = $clog2(PACKET_SIZE_TX);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(BITS_PER_WORD - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  tx_state_e                state_q;
  logic [BAUD_W-1:0]        baud_q;
  logic [BIT_W-1:0]         bit_q;
  logic [BITS_PER_WORD-1:0] shift_q;
  logic                     tx_q;
  logic                     baud_end;

  assign baud_end = (baud_q == BAUD_LAST);
  assign done     = (state_q == StStop) && baud_end && (bit_q == STOP_LAST);
  assign tx       = tx_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StStart;
            baud_q  <= '0;
            tx_q    <= 1'b0;
          end
        end

        // Data is sampled only here, so the parent's word must be stable by the end of START.
        StStart: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= StData;
            tx_q    <= data[0];
            shift_q <= data >> 1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        StData: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == DATA_LAST) begin
              bit_q   <= '0;
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        // A start coinciding with done chains the next word with no idle gap.
        StStop: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == STOP_LAST) begin
              bit_q <= '0;
              if (start) begin
                state_q <= StStart;
                tx_q    <= 1'b0;
              end else begin
                state_q <= StIdle;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mvm_result_uart_tx.sv
// Accepts one y vector over valid/ready and streams it out as back-to-back UART frames.
module mvm_result_uart_tx
  import mvm_uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = CLOCKS_PER_PULSE_DEF,
  parameter int unsigned BITS_PER_WORD    = BITS_PER_WORD_DEF,
  parameter int unsigned PACKET_SIZE_TX   = PACKET_SIZE_TX_DEF,
  parameter int unsigned W_Y_OUT          = 8,
  parameter int unsigned R                = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [R*W_Y_OUT-1:0] s_data,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned VEC_W     = R * W_Y_OUT;
  localparam int unsigned NUM_WORDS = num_words(R, W_Y_OUT, BITS_PER_WORD);
  localparam int unsigned WORD_W    = $clog2(NUM_WORDS + 1);

  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(NUM_WORDS - 1);

  if ((VEC_W % BITS_PER_WORD) != 0) begin : g_bad_word_split
    $error("R*W_Y_OUT must be a multiple of BITS_PER_WORD");
  end
  if (PACKET_SIZE_TX < BITS_PER_WORD + 2) begin : g_bad_stop_bits
    $error("PACKET_SIZE_TX leaves no room for a stop bit");
  end

  logic [VEC_W-1:0]  vec_q;
  logic [WORD_W-1:0] word_q;
  logic              s_ready_q;
  logic              busy_q;
  logic              accept;
  logic              last_word;
  logic              frame_start;
  logic              frame_done;

  assign accept      = s_valid && s_ready_q;
  assign last_word   = (word_q == WORD_LAST);
  assign frame_start = accept || (frame_done && !last_word);
  assign s_ready     = s_ready_q;
  assign busy        = busy_q;

  // s_data is captured only on accept; everything downstream reads the latched copy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vec_q     <= '0;
      word_q    <= '0;
      s_ready_q <= 1'b1;
      busy_q    <= 1'b0;
    end else if (accept) begin
      vec_q     <= s_data;
      word_q    <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b1;
    end else if (frame_done) begin
      if (last_word) begin
        word_q    <= '0;
        s_ready_q <= 1'b1;
        busy_q    <= 1'b0;
      end else begin
        word_q <= word_q + 1'b1;
        vec_q  <= vec_q >> BITS_PER_WORD;
      end
    end
  end

  uart_tx_frame #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
    .BITS_PER_WORD   (BITS_PER_WORD),
    .PACKET_SIZE_TX  (PACKET_SIZE_TX)
  ) u_frame (
    .clk  (clk),
    .rstn (rstn),
    .start(frame_start),
    .data (vec_q[BITS_PER_WORD-1:0]),
    .done (frame_done),
    .tx   (tx)
  );

endmodule
